shift_ctrl: RTL

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_if.sv | 31 +++
 rtl/shift_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/shift_ctrl_if.sv
// Bundle between shift_ctrl, its word source, the external shift register
// and the serial stream consumer. slave = controller side, master = environment.
interface shift_ctrl_if #(
  parameter int SHIFT_WIDTH = 4
) ();
  logic                   in_valid;
  logic [SHIFT_WIDTH-1:0] in_data;
  logic                   in_ready;
  logic                   abort;
  logic                   sr_load;
  logic                   sr_en;
  logic [SHIFT_WIDTH-1:0] sr_data;
  logic                   sr_shiftin;
  logic                   sr_shiftout;
  logic                   ser_valid;
  logic                   ser_bit;
  logic                   ser_first;
  logic                   done;

  modport slave (
    input  in_valid, in_data, abort, sr_shiftout,
    output in_ready, sr_load, sr_en, sr_data, sr_shiftin,
           ser_valid, ser_bit, ser_first, done
  );

  modport master (
    output in_valid, in_data, abort, sr_shiftout,
    input  in_ready, sr_load, sr_en, sr_data, sr_shiftin,
           ser_valid, ser_bit, ser_first, done
  );
endinterface

// File: rtl/shift_ctrl.sv
// shift_ctrl: serializes a parallel word through an external shift register.
// Sequence per word: IDLE -> LOAD (1) -> SHIFT (SHIFT_WIDTH) -> [PARITY (1)] -> DONE (1).
// Optional feature: define SHIFT_CTRL_PARITY_EN to append an even-parity bit.
module shift_ctrl #(
  parameter int SHIFT_WIDTH = 4,
  parameter bit FILL_BIT    = 1'b0
) (
  input  logic            clk,
  input  logic            sclr,
  shift_ctrl_if.slave     bus
);
  localparam int CW = $clog2(SHIFT_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(SHIFT_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    DONE   = 3'd3
`ifdef SHIFT_CTRL_PARITY_EN
    , PARITY = 3'd4
`endif
  } state_t;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [SHIFT_WIDTH-1:0] word_q, word_d;
`ifdef SHIFT_CTRL_PARITY_EN
  logic                   par_q, par_d;
`endif

  // State, bit counter and captured word; sclr overrides everything
  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      word_q  <= '0;
`ifdef SHIFT_CTRL_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
`ifdef SHIFT_CTRL_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Next-state sequencing; abort wins over normal progress in LOAD/SHIFT/PARITY
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
`ifdef SHIFT_CTRL_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = LOAD;
          word_d  = bus.in_data;
`ifdef SHIFT_CTRL_PARITY_EN
          par_d   = ^bus.in_data;
`endif
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = bus.abort ? IDLE : SHIFT;
      end
      SHIFT: begin
        if (bus.abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
`ifdef SHIFT_CTRL_PARITY_EN
          state_d = PARITY;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
`ifdef SHIFT_CTRL_PARITY_EN
      PARITY: begin
        state_d = bus.abort ? IDLE : DONE;
      end
`endif
      DONE: begin
        // abort is deliberately ignored so the frame completes normally
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Moore strobes decoded from state; ser_bit forced low when not valid
  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.sr_load   = (state_q == LOAD);
    bus.sr_en     = (state_q == SHIFT);
    bus.sr_data   = word_q;
    bus.sr_shiftin = FILL_BIT;
    bus.ser_valid = (state_q == SHIFT);
    bus.ser_bit   = (state_q == SHIFT) ? bus.sr_shiftout : 1'b0;
    bus.ser_first = (state_q == SHIFT) && (cnt_q == '0);
    bus.done      = (state_q == DONE);
`ifdef SHIFT_CTRL_PARITY_EN
    if (state_q == PARITY) begin
      bus.ser_valid = 1'b1;
      bus.ser_bit   = par_q;
    end
`endif
  end
endmodule
